// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier:
// FSM states, default widths and the 3-bit window recode classification.
package booth_pkg;

    localparam int W_DEF      = 31;
    localparam int N_ITER_DEF = (W_DEF + 1) / 2;
    localparam int PW_DEF     = 2 * W_DEF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Partial-product selections a Booth window can ask for.
    typedef enum logic [2:0] {
        ZERO,
        P1,
        P2,
        M2,
        M1
    } pp_kind_t;

    function automatic pp_kind_t decode_win(input logic [2:0] win);
        pp_kind_t kind;
        kind = ZERO;
        case (win)
            3'b001, 3'b010: kind = P1;
            3'b011:         kind = P2;
            3'b100:         kind = M2;
            3'b101, 3'b110: kind = M1;
            default:        kind = ZERO;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth partial-product selector: maps one 3-bit multiplier window
// onto 0, +a, +2a, -2a or -a, all held in W+1 bits.
module booth_pp_sel
    import booth_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [2:0]   win,
    input  logic [W-1:0] areg,
    output logic [W:0]   pp
);

    logic [W:0] a_one;
    logic [W:0] a_two;

    assign a_one = {areg[W-1], areg};
    assign a_two = {areg, 1'b0};

    // Negations wrap modulo 2^(W+1), matching the datapath width of pp.
    always_comb begin
        pp = '0;
        case (decode_win(win))
            P1:      pp = a_one;
            P2:      pp = a_two;
            M2:      pp = -a_two;
            M1:      pp = -a_one;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: one window per clock, valid/ready on
// both sides, product registered once the last window has been accumulated.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int N_ITER = (W + 1) / 2,
    parameter int PW     = 2 * W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] product,
    output logic          busy
);

    localparam int CW = $clog2(N_ITER);

    state_t        state;
    logic [W-1:0]  areg;
    logic [W+1:0]  mreg;
    logic [PW-1:0] acc;
    logic [CW-1:0] count;

    logic [W:0]    pp;
    logic [PW-1:0] pp_ext;
    logic [PW-1:0] acc_next;

    booth_pp_sel #(.W(W)) u_pp_sel (
        .win  (mreg[2:0]),
        .areg (areg),
        .pp   (pp)
    );

    // Window k carries weight 4^k, hence the shift by twice the iteration count.
    assign pp_ext   = {{(PW-W-1){pp[W]}}, pp};
    assign acc_next = acc + (pp_ext << {count, 1'b0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            product   <= '0;
            areg      <= '0;
            mreg      <= '0;
            acc       <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        areg     <= a;
                        mreg     <= {b[W-1], b, 1'b0};
                        acc      <= '0;
                        count    <= '0;
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    mreg  <= {{2{mreg[W+1]}}, mreg[W+1:2]};
                    count <= count + 1'b1;
                    if (count == CW'(N_ITER - 1)) begin
                        state     <= DONE;
                        product   <= acc_next;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
